// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// downstream stall hold, branch flush and writeback refresh of held operands.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_read1regsel,
    input  logic [2:0]  id_read2regsel,
    input  logic        id_uses1,
    input  logic        id_uses2,
    input  logic [15:0] id_read1data,
    input  logic [15:0] id_read2data,
    input  logic [2:0]  id_writeregsel,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic [3:0]  id_op,
    input  logic [15:0] id_imm,
    input  logic        wb_write,
    input  logic [2:0]  wb_writeregsel,
    input  logic [15:0] wb_writedata,
    input  logic        ex_stall,
    input  logic        flush,
    input  logic        cnt_clr,
    output logic        ex_valid,
    output logic        ex_uses1,
    output logic        ex_uses2,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [2:0]  ex_read1regsel,
    output logic [2:0]  ex_read2regsel,
    output logic [2:0]  ex_writeregsel,
    output logic [15:0] ex_read1data,
    output logic [15:0] ex_read2data,
    output logic [15:0] ex_imm,
    output logic [3:0]  ex_op,
    output logic        stall_id,
    output logic [15:0] bubble_count
);

    logic        valid_q, valid_d;
    logic        uses1_q, uses1_d, uses2_q, uses2_d;
    logic        regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
    logic [2:0]  rsel1_q, rsel1_d, rsel2_q, rsel2_d, wsel_q, wsel_d;
    logic [15:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] bubble_count_q, bubble_count_d;
    logic        hazard;

    always_comb begin
        hazard = id_valid & valid_q & memread_q & regwrite_q &
                 ((id_uses1 & (id_read1regsel == wsel_q)) |
                  (id_uses2 & (id_read2regsel == wsel_q)));
        stall_id = ex_stall | (hazard & ~flush);
    end

    always_comb begin
        valid_d    = valid_q;
        uses1_d    = uses1_q;
        uses2_d    = uses2_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        rsel1_d    = rsel1_q;
        rsel2_d    = rsel2_q;
        wsel_d     = wsel_q;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        imm_d      = imm_q;
        op_d       = op_q;
        if (ex_stall) begin
            // Held operands track writeback so execute never sees a stale value.
            if (wb_write && valid_q && uses1_q && (wb_writeregsel == rsel1_q))
                rdata1_d = wb_writedata;
            if (wb_write && valid_q && uses2_q && (wb_writeregsel == rsel2_q))
                rdata2_d = wb_writedata;
        end else if (flush || hazard) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else begin
            valid_d    = id_valid;
            uses1_d    = id_uses1;
            uses2_d    = id_uses2;
            regwrite_d = id_regwrite & id_valid;
            memread_d  = id_memread & id_valid;
            memwrite_d = id_memwrite & id_valid;
            rsel1_d    = id_read1regsel;
            rsel2_d    = id_read2regsel;
            wsel_d     = id_writeregsel;
            rdata1_d   = id_read1data;
            rdata2_d   = id_read2data;
            imm_d      = id_imm;
            op_d       = id_op;
        end

        bubble_count_d = bubble_count_q;
        if (cnt_clr)
            bubble_count_d = 16'h0000;
        else if (!ex_stall && !flush && hazard && (bubble_count_q != 16'hFFFF))
            bubble_count_d = bubble_count_q + 16'h0001;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q        <= 1'b0;
            uses1_q        <= 1'b0;
            uses2_q        <= 1'b0;
            regwrite_q     <= 1'b0;
            memread_q      <= 1'b0;
            memwrite_q     <= 1'b0;
            rsel1_q        <= 3'd0;
            rsel2_q        <= 3'd0;
            wsel_q         <= 3'd0;
            rdata1_q       <= 16'h0000;
            rdata2_q       <= 16'h0000;
            imm_q          <= 16'h0000;
            op_q           <= 4'h0;
            bubble_count_q <= 16'h0000;
        end else begin
            valid_q        <= valid_d;
            uses1_q        <= uses1_d;
            uses2_q        <= uses2_d;
            regwrite_q     <= regwrite_d;
            memread_q      <= memread_d;
            memwrite_q     <= memwrite_d;
            rsel1_q        <= rsel1_d;
            rsel2_q        <= rsel2_d;
            wsel_q         <= wsel_d;
            rdata1_q       <= rdata1_d;
            rdata2_q       <= rdata2_d;
            imm_q          <= imm_d;
            op_q           <= op_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_uses1       = uses1_q;
    assign ex_uses2       = uses2_q;
    assign ex_regwrite    = regwrite_q;
    assign ex_memread     = memread_q;
    assign ex_memwrite    = memwrite_q;
    assign ex_read1regsel = rsel1_q;
    assign ex_read2regsel = rsel2_q;
    assign ex_writeregsel = wsel_q;
    assign ex_read1data   = rdata1_q;
    assign ex_read2data   = rdata2_q;
    assign ex_imm         = imm_q;
    assign ex_op          = op_q;
    assign bubble_count   = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, advance, load-use, hold/refresh,
// flush, counter saturation/clear and mid-run reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses1, id_uses2, id_regwrite, id_memread, id_memwrite;
    logic [2:0]  id_read1regsel, id_read2regsel, id_writeregsel;
    logic [15:0] id_read1data, id_read2data, id_imm;
    logic [3:0]  id_op;
    logic        wb_write;
    logic [2:0]  wb_writeregsel;
    logic [15:0] wb_writedata;
    logic        ex_stall, flush, cnt_clr;
    logic        ex_valid, ex_uses1, ex_uses2, ex_regwrite, ex_memread, ex_memwrite;
    logic [2:0]  ex_read1regsel, ex_read2regsel, ex_writeregsel;
    logic [15:0] ex_read1data, ex_read2data, ex_imm;
    logic [3:0]  ex_op;
    logic        stall_id;
    logic [15:0] bubble_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_read1regsel(id_read1regsel), .id_read2regsel(id_read2regsel),
        .id_uses1(id_uses1), .id_uses2(id_uses2),
        .id_read1data(id_read1data), .id_read2data(id_read2data),
        .id_writeregsel(id_writeregsel), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_op(id_op), .id_imm(id_imm),
        .wb_write(wb_write), .wb_writeregsel(wb_writeregsel), .wb_writedata(wb_writedata),
        .ex_stall(ex_stall), .flush(flush), .cnt_clr(cnt_clr),
        .ex_valid(ex_valid), .ex_uses1(ex_uses1), .ex_uses2(ex_uses2),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_read1regsel(ex_read1regsel), .ex_read2regsel(ex_read2regsel),
        .ex_writeregsel(ex_writeregsel),
        .ex_read1data(ex_read1data), .ex_read2data(ex_read2data), .ex_imm(ex_imm),
        .ex_op(ex_op), .stall_id(stall_id), .bubble_count(bubble_count)
    );

    // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                          input logic u1, input logic u2,
                          input logic [15:0] d1, input logic [15:0] d2,
                          input logic [2:0] ws, input logic rw, input logic mr,
                          input logic mw, input logic [3:0] op, input logic [15:0] imm);
        id_valid = v; id_read1regsel = s1; id_read2regsel = s2;
        id_uses1 = u1; id_uses2 = u2; id_read1data = d1; id_read2data = d2;
        id_writeregsel = ws; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
        id_op = op; id_imm = imm;
        #1;
    endtask

    task automatic id_idle();
        set_id(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'h0, 16'h0);
    endtask

    // Load to r3 with no sources of its own.
    task automatic id_load_r3();
        set_id(1, 0, 0, 0, 0, 16'h0, 16'h0, 3, 1, 1, 0, 4'h8, 16'h0010);
    endtask

    // Dependent instruction reading r3 on source 2.
    task automatic id_dep_r3();
        set_id(1, 1, 3, 1, 1, 16'h0101, 16'h0303, 6, 1, 0, 0, 4'h1, 16'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ex_stall = 0; flush = 0; cnt_clr = 0;
        wb_write = 0; wb_writeregsel = 0; wb_writedata = 0;
        id_idle();
        #3;
        tests++;
        if ({ex_valid, ex_uses1, ex_uses2, ex_regwrite, ex_memread, ex_memwrite} !== 6'b0 ||
            {ex_read1regsel, ex_read2regsel, ex_writeregsel} !== 9'b0 ||
            {ex_read1data, ex_read2data, ex_imm, ex_op} !== 52'b0 || bubble_count !== 16'h0) begin
            fails++; $display("FAIL reset_state: outputs not all zero (valid=%b bc=%h)", ex_valid, bubble_count);
        end
        tests++;
        if (stall_id !== 1'b0) begin fails++; $display("FAIL reset_stall_id: got %b want 0", stall_id); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_advance();
        set_id(1, 1, 2, 1, 1, 16'h1234, 16'hABCD, 5, 1, 0, 0, 4'h3, 16'h0042);
        tests++;
        if (stall_id !== 1'b0) begin fails++; $display("FAIL adv_stall_id: got %b want 0", stall_id); end
        tick();
        id_idle();
        tests++;
        if (ex_valid !== 1 || ex_read1data !== 16'h1234 || ex_read2data !== 16'hABCD ||
            ex_writeregsel !== 3'd5 || ex_op !== 4'h3 || ex_regwrite !== 1 || ex_imm !== 16'h0042) begin
            fails++;
            $display("FAIL adv_fields: valid=%b d1=%h d2=%h ws=%0d op=%h want 1 1234 abcd 5 3",
                     ex_valid, ex_read1data, ex_read2data, ex_writeregsel, ex_op);
        end
        tests++;
        if (stall_id !== 1'b0) begin fails++; $display("FAIL adv_stall_after: got %b want 0", stall_id); end
        tick();
        tests++;
        if (ex_valid !== 0 || ex_regwrite !== 0) begin
            fails++; $display("FAIL adv_idle: valid=%b rw=%b want 0 0", ex_valid, ex_regwrite);
        end
    endtask

    task automatic test_load_use();
        id_load_r3();
        tick();
        id_dep_r3();
        tests++;
        if (stall_id !== 1'b1) begin fails++; $display("FAIL lu_stall_id: got %b want 1", stall_id); end
        tick();
        tests++;
        if (ex_valid !== 0 || ex_memread !== 0 || ex_regwrite !== 0 || bubble_count !== 16'd1) begin
            fails++; $display("FAIL lu_bubble: valid=%b mr=%b bc=%0d want 0 0 1", ex_valid, ex_memread, bubble_count);
        end
        tests++;
        if (stall_id !== 1'b0) begin fails++; $display("FAIL lu_stall_drop: got %b want 0", stall_id); end
        tick();
        id_idle();
        tests++;
        if (ex_valid !== 1 || ex_read2regsel !== 3'd3 || ex_read2data !== 16'h0303 ||
            ex_writeregsel !== 3'd6 || bubble_count !== 16'd1) begin
            fails++; $display("FAIL lu_dep_enter: valid=%b s2=%0d d2=%h ws=%0d bc=%0d", ex_valid,
                              ex_read2regsel, ex_read2data, ex_writeregsel, bubble_count);
        end
    endtask

    task automatic test_no_use();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        tests++;
        if (bubble_count !== 16'd0) begin fails++; $display("FAIL clr_count: got %0d want 0", bubble_count); end
        id_load_r3();
        tick();
        set_id(1, 1, 3, 1, 0, 16'h0101, 16'h0303, 6, 1, 0, 0, 4'h1, 16'h0);
        tests++;
        if (stall_id !== 1'b0) begin fails++; $display("FAIL nouse_stall_id: got %b want 0", stall_id); end
        tick();
        id_idle();
        tests++;
        if (ex_valid !== 1 || ex_writeregsel !== 3'd6 || bubble_count !== 16'd0) begin
            fails++; $display("FAIL nouse_advance: valid=%b ws=%0d bc=%0d want 1 6 0", ex_valid, ex_writeregsel, bubble_count);
        end
    endtask

    task automatic test_hold_refresh();
        set_id(1, 2, 2, 1, 1, 16'h1111, 16'h2222, 4, 1, 0, 0, 4'h5, 16'h0077);
        tick();
        set_id(1, 7, 7, 1, 1, 16'hEEEE, 16'hEEEE, 7, 1, 0, 1, 4'hE, 16'hEEEE);
        ex_stall = 1;
        wb_write = 1; wb_writeregsel = 3; wb_writedata = 16'hDEAD;
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (stall_id !== 1'b1) begin fails++; $display("FAIL hold_stall_id c%0d: got %b want 1", c, stall_id); end
            tick();
            if (c == 0) begin
                tests++;
                if (ex_read1data !== 16'h1111 || ex_read2data !== 16'h2222) begin
                    fails++; $display("FAIL hold_nomatch: d1=%h d2=%h want 1111 2222", ex_read1data, ex_read2data);
                end
                wb_writeregsel = 2; wb_writedata = 16'h00FF;
            end else begin
                tests++;
                if (ex_read1data !== 16'h00FF || ex_read2data !== 16'h00FF) begin
                    fails++; $display("FAIL hold_refresh c%0d: d1=%h d2=%h want 00ff 00ff", c, ex_read1data, ex_read2data);
                end
                wb_write = 0; wb_writedata = 16'h0000;
            end
            tests++;
            if (ex_valid !== 1 || ex_op !== 4'h5 || ex_writeregsel !== 3'd4 || ex_imm !== 16'h0077 || ex_memwrite !== 0) begin
                fails++; $display("FAIL hold_fields c%0d: valid=%b op=%h ws=%0d imm=%h", c, ex_valid, ex_op, ex_writeregsel, ex_imm);
            end
            #1;
        end
        ex_stall = 0;
        id_idle();
        tick();
    endtask

    task automatic test_flush();
        id_load_r3();
        tick();
        id_dep_r3();
        flush = 1;
        #1;
        tests++;
        if (stall_id !== 1'b0) begin fails++; $display("FAIL flush_stall_id: got %b want 0", stall_id); end
        tick();
        tests++;
        if (ex_valid !== 0 || ex_memread !== 0 || ex_writeregsel !== 3'd3 || ex_op !== 4'h8 || bubble_count !== 16'd0) begin
            fails++; $display("FAIL flush_bubble: valid=%b mr=%b ws=%0d op=%h bc=%0d", ex_valid, ex_memread,
                              ex_writeregsel, ex_op, bubble_count);
        end
        flush = 0;
        id_load_r3();
        tick();
        id_dep_r3();
        flush = 1; ex_stall = 1;
        #1;
        tests++;
        if (stall_id !== 1'b1) begin fails++; $display("FAIL flushstall_stall_id: got %b want 1", stall_id); end
        tick();
        tests++;
        if (ex_valid !== 1 || ex_memread !== 1 || ex_regwrite !== 1 || bubble_count !== 16'd0) begin
            fails++; $display("FAIL flushstall_hold: valid=%b mr=%b rw=%b bc=%0d", ex_valid, ex_memread, ex_regwrite, bubble_count);
        end
        flush = 0; ex_stall = 0;
        id_idle();
        tick();
    endtask

    task automatic do_hazard();
        id_load_r3();
        tick();
        id_dep_r3();
        tick();
    endtask

    task automatic test_saturate_clear_reset();
        logic [15:0] exp_bc [3];
        exp_bc[0] = 16'hFFFE; exp_bc[1] = 16'hFFFF; exp_bc[2] = 16'hFFFF;
        do_hazard();
        do_hazard();
        tests++;
        if (bubble_count !== 16'd2) begin fails++; $display("FAIL count_two: got %0d want 2", bubble_count); end
        // Preload near the top so saturation is reached in a few cycles.
        dut.bubble_count_q = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            do_hazard();
            tests++;
            if (bubble_count !== exp_bc[i]) begin
                fails++; $display("FAIL saturate %0d: got %h want %h", i, bubble_count, exp_bc[i]);
            end
        end
        id_load_r3();
        tick();
        id_dep_r3();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        tests++;
        if (bubble_count !== 16'd0 || ex_valid !== 0) begin
            fails++; $display("FAIL clr_priority: bc=%h valid=%b want 0 0", bubble_count, ex_valid);
        end
        set_id(1, 1, 2, 1, 1, 16'h5555, 16'h6666, 2, 1, 0, 1, 4'h9, 16'h1234);
        tick();
        do_hazard();
        ex_stall = 1;
        #2;
        rst = 0;
        #1;
        tests++;
        if ({ex_valid, ex_uses1, ex_uses2, ex_regwrite, ex_memread, ex_memwrite} !== 6'b0 ||
            {ex_read1regsel, ex_read2regsel, ex_writeregsel} !== 9'b0 ||
            {ex_read1data, ex_read2data, ex_imm, ex_op} !== 52'b0 || bubble_count !== 16'h0) begin
            fails++; $display("FAIL midrun_reset: valid=%b d1=%h bc=%h", ex_valid, ex_read1data, bubble_count);
        end
        tests++;
        if (stall_id !== 1'b1) begin fails++; $display("FAIL midrun_stall_id: got %b want 1", stall_id); end
        ex_stall = 0;
        #1;
        rst = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_advance();
        test_load_use();
        test_no_use();
        test_hold_refresh();
        test_flush();
        test_saturate_clear_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
